// File: rtl/fifo_dispatch.sv
// Write-side dispatcher: captures one packet from the producer and pushes it into one lane FIFO.
// Optional build macro FIFO_DISPATCH_AUTO_LANE_EN enables round-robin lane selection for in_lane==0.
module fifo_dispatch #(
  parameter int unsigned N_LANE  = 20,
  parameter int unsigned LANE_W  = 5,
  parameter int unsigned PKT_W   = 36,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_req,
  input  logic [PKT_W-1:0]  in_packet,
  input  logic [LANE_W-1:0] in_lane,
  output logic              in_gnt,
  output logic [N_LANE-1:0] write_req,
  output logic [PKT_W-1:0]  packet_out,
  input  logic [N_LANE-1:0] write_gnt,
  input  logic [N_LANE-1:0] full,
  output logic              busy,
  output logic [15:0]       drop_cnt
);

  localparam int unsigned TmoW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StCheck, StPush} state_e;

  state_e              state_q, state_d;
  logic [PKT_W-1:0]    pkt_q, pkt_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic                in_gnt_q, in_gnt_d;
  logic [N_LANE-1:0]   write_req_q, write_req_d;
  logic [PKT_W-1:0]    packet_out_q, packet_out_d;
  logic                busy_q, busy_d;
  logic [15:0]         drop_cnt_q, drop_cnt_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;

  logic [LANE_W-1:0]   eff_lane;
  logic [N_LANE-1:0]   eff_oh;
  logic                lane_ok;
  logic                stall_auto;

`ifdef FIFO_DISPATCH_AUTO_LANE_EN
  logic [LANE_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [LANE_W-1:0]   auto_lane;
  logic                auto_found;
  logic [N_LANE-1:0]   full_shift;
  int unsigned         scan_idx;

  // First non-full lane at or after rr_ptr, wrapping N_LANE -> 1.
  always_comb begin
    auto_found = 1'b0;
    auto_lane  = '0;
    full_shift = '0;
    scan_idx   = 0;
    for (int unsigned k = 0; k < N_LANE; k++) begin
      scan_idx   = (32'(rr_ptr_q) + k - 1) % N_LANE;
      full_shift = full >> scan_idx;
      if (!auto_found && !full_shift[0]) begin
        auto_found = 1'b1;
        auto_lane  = LANE_W'(scan_idx + 1);
      end
    end
  end

  always_comb begin
    eff_lane   = lane_q;
    stall_auto = 1'b0;
    if (lane_q == '0) begin
      eff_lane   = auto_lane;
      stall_auto = !auto_found;
    end
  end
`else
  always_comb begin
    eff_lane   = lane_q;
    stall_auto = 1'b0;
  end
`endif

  assign lane_ok = (eff_lane != '0) && (32'(eff_lane) <= N_LANE);
  assign eff_oh  = N_LANE'(1) << (eff_lane - LANE_W'(1));

  always_comb begin
    state_d      = state_q;
    pkt_d        = pkt_q;
    lane_d       = lane_q;
    in_gnt_d     = 1'b0;
    write_req_d  = write_req_q;
    packet_out_d = packet_out_q;
    drop_cnt_d   = drop_cnt_q;
    tmo_d        = tmo_q;
`ifdef FIFO_DISPATCH_AUTO_LANE_EN
    rr_ptr_d     = rr_ptr_q;
`endif
    case (state_q)
      StIdle: begin
        if (in_req) begin
          pkt_d    = in_packet;
          lane_d   = in_lane;
          in_gnt_d = 1'b1;
          state_d  = StCheck;
        end
      end
      StCheck: begin
        if (stall_auto) begin
          state_d = StCheck;
        end else if (!lane_ok) begin
          if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
          state_d = StIdle;
        end else if ((full & eff_oh) == '0) begin
          packet_out_d = pkt_q;
          write_req_d  = eff_oh;
          tmo_d        = '0;
          state_d      = StPush;
`ifdef FIFO_DISPATCH_AUTO_LANE_EN
          if (lane_q == '0) rr_ptr_d = LANE_W'((32'(eff_lane) % N_LANE) + 1);
`endif
        end
      end
      StPush: begin
        // Only the grant bit of the lane being written is honoured.
        if ((write_gnt & write_req_q) != '0) begin
          write_req_d = '0;
          state_d     = StIdle;
        end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
          write_req_d = '0;
          if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
          state_d     = StIdle;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      pkt_q        <= '0;
      lane_q       <= '0;
      in_gnt_q     <= 1'b0;
      write_req_q  <= '0;
      packet_out_q <= '0;
      busy_q       <= 1'b0;
      drop_cnt_q   <= '0;
      tmo_q        <= '0;
`ifdef FIFO_DISPATCH_AUTO_LANE_EN
      rr_ptr_q     <= LANE_W'(1);
`endif
    end else begin
      state_q      <= state_d;
      pkt_q        <= pkt_d;
      lane_q       <= lane_d;
      in_gnt_q     <= in_gnt_d;
      write_req_q  <= write_req_d;
      packet_out_q <= packet_out_d;
      busy_q       <= busy_d;
      drop_cnt_q   <= drop_cnt_d;
      tmo_q        <= tmo_d;
`ifdef FIFO_DISPATCH_AUTO_LANE_EN
      rr_ptr_q     <= rr_ptr_d;
`endif
    end
  end

  assign in_gnt     = in_gnt_q;
  assign write_req  = write_req_q;
  assign packet_out = packet_out_q;
  assign busy       = busy_q;
  assign drop_cnt   = drop_cnt_q;

endmodule
